// File: rtl/dfx_axil_pkg.sv
// Shared constants and helpers for the DFX AXI4-Lite control/status register block.
package dfx_axil_pkg;

  localparam int unsigned MAX_CH = 16;

  // Register byte offsets within one 16-byte channel window.
  localparam logic [3:0] CTRL     = 4'h0;
  localparam logic [3:0] STATUS   = 4'h4;
  localparam logic [3:0] DOORBELL = 4'h8;
  localparam logic [3:0] SCRATCH  = 4'hC;

  // AXI response codes.
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  // Word index within a channel window (addr[3:2]).
  typedef enum logic [1:0] {
    WordCtrl     = 2'd0,
    WordStatus   = 2'd1,
    WordDoorbell = 2'd2,
    WordScratch  = 2'd3
  } reg_word_e;

  // Merge new data into an old word, one byte lane per strobe bit.
  function automatic logic [31:0] apply_strb(logic [31:0] old, logic [31:0] data,
                                             logic [3:0] strb);
    logic [31:0] res;
    res = old;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[i*8 +: 8] = data[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dfx_axil_ctrl_regs_if.sv
// AXI4-Lite bus between the PCIe interconnect (master) and the DFX register block (slave).
interface dfx_axil_ctrl_regs_if #(
  parameter int unsigned ADDR_W = 12
);
  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awprot;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/dfx_ctrl_channel.sv
// One register channel: CTRL, SCRATCH, sampled STATUS and a doorbell pending flag.
module dfx_ctrl_channel
  import dfx_axil_pkg::*;
#(
  parameter logic [31:0] CTRL_RST = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  reg_word_e   wr_word,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_strb,
  input  logic        ack,
  input  logic [31:0] status,
  input  reg_word_e   rd_word,
  output logic [31:0] ctrl,
  output logic        pending,
  output logic [31:0] rd_data
);

  logic [31:0] ctrl_q;
  logic [31:0] scratch_q;
  logic [31:0] status_q;
  logic        pending_q;
  logic        db_set;

  // Only a doorbell write with bit 0 set (and its byte lane enabled) rings the bell.
  assign db_set = wr_en && (wr_word == WordDoorbell) && wr_strb[0] && wr_data[0];

  // Register state; a doorbell set beats a same-cycle acknowledge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q    <= CTRL_RST;
      scratch_q <= '0;
      status_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      status_q <= status;
      if (wr_en && (wr_word == WordCtrl)) ctrl_q <= apply_strb(ctrl_q, wr_data, wr_strb);
      if (wr_en && (wr_word == WordScratch)) scratch_q <= apply_strb(scratch_q, wr_data, wr_strb);
      if (db_set) begin
        pending_q <= 1'b1;
      end else if (ack) begin
        pending_q <= 1'b0;
      end
    end
  end

  // Read mux for this channel's window.
  always_comb begin
    rd_data = '0;
    unique case (rd_word)
      WordCtrl:     rd_data = ctrl_q;
      WordStatus:   rd_data = status_q;
      WordDoorbell: rd_data = {31'b0, pending_q};
      WordScratch:  rd_data = scratch_q;
    endcase
  end

  assign ctrl    = ctrl_q;
  assign pending = pending_q;

endmodule

// File: rtl/dfx_axil_ctrl_regs.sv
// AXI4-Lite control/status register block serving NUM_CH MCU channels in the DFX region.
module dfx_axil_ctrl_regs
  import dfx_axil_pkg::*;
#(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned ADDR_W   = 12,
  parameter logic [31:0] CTRL_RST = 32'h0
) (
  input  logic                     AxiBusClock,
  input  logic                     xAxiBusReset_n,
  dfx_axil_ctrl_regs_if.slave      xPcieToDfx_AXI,
  output logic [NUM_CH*32-1:0]     sMcuInputControl,
  input  logic [NUM_CH*32-1:0]     sMcuOutputControl,
  output logic [NUM_CH-1:0]        mDoorbell,
  input  logic [NUM_CH-1:0]        sDoorbellAck,
  output logic                     mDoorbellIrq
);

  // Write path state.
  logic              aw_held_q, aw_held_d;
  logic              w_held_q, w_held_d;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [31:0]       w_data_q;
  logic [3:0]        w_strb_q;
  logic              awready_q, wready_q;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q;

  // Read path state.
  logic              arready_q;
  logic              rvalid_q, rvalid_d;
  logic [1:0]        rresp_q;
  logic [31:0]       rdata_q;

  logic              irq_q;

  logic              aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic              commit;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [3:0]        wr_strb;
  logic [31:0]       wr_ch, rd_ch;
  logic              wr_mapped, rd_mapped;
  logic [31:0]       rd_data_mux;
  logic [NUM_CH-1:0] wr_en;
  logic [31:0]       ch_rd_data [NUM_CH];
  logic              unused_prot;

  assign unused_prot = ^{xPcieToDfx_AXI.awprot, xPcieToDfx_AXI.arprot};

  assign aw_hs = xPcieToDfx_AXI.awvalid && awready_q;
  assign w_hs  = xPcieToDfx_AXI.wvalid && wready_q;
  assign b_hs  = bvalid_q && xPcieToDfx_AXI.bready;
  assign ar_hs = xPcieToDfx_AXI.arvalid && arready_q;
  assign r_hs  = rvalid_q && xPcieToDfx_AXI.rready;

  // A beat arriving this cycle is used directly, so a same-cycle AW+W commits immediately.
  assign wr_addr = aw_hs ? xPcieToDfx_AXI.awaddr : aw_addr_q;
  assign wr_data = w_hs ? xPcieToDfx_AXI.wdata : w_data_q;
  assign wr_strb = w_hs ? xPcieToDfx_AXI.wstrb : w_strb_q;

  assign wr_ch     = 32'(wr_addr[ADDR_W-1:4]);
  assign rd_ch     = 32'(xPcieToDfx_AXI.araddr[ADDR_W-1:4]);
  assign wr_mapped = (wr_addr[1:0] == 2'b00) && (wr_ch < NUM_CH);
  assign rd_mapped = (xPcieToDfx_AXI.araddr[1:0] == 2'b00) && (rd_ch < NUM_CH);

  // Next-state for holds and response valids.
  always_comb begin
    commit    = (aw_held_q || aw_hs) && (w_held_q || w_hs);
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    bvalid_d  = bvalid_q;
    rvalid_d  = rvalid_q;
    if (aw_hs) aw_held_d = 1'b1;
    if (w_hs) w_held_d = 1'b1;
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
    end
    if (b_hs) bvalid_d = 1'b0;
    if (commit) bvalid_d = 1'b1;
    if (r_hs) rvalid_d = 1'b0;
    if (ar_hs) rvalid_d = 1'b1;
  end

  // Select the addressed channel's read data; unmapped reads return zero.
  always_comb begin
    rd_data_mux = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (rd_ch == c) rd_data_mux = ch_rd_data[c];
    end
    if (!rd_mapped) rd_data_mux = '0;
  end

  // AXI handshake registers; readies are registered so they stay low through reset.
  always_ff @(posedge AxiBusClock) begin
    if (!xAxiBusReset_n) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= OKAY;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      bvalid_q  <= bvalid_d;
      rvalid_q  <= rvalid_d;
      awready_q <= !aw_held_d && !bvalid_d;
      wready_q  <= !w_held_d && !bvalid_d;
      arready_q <= !rvalid_d;
      if (aw_hs) aw_addr_q <= xPcieToDfx_AXI.awaddr;
      if (w_hs) begin
        w_data_q <= xPcieToDfx_AXI.wdata;
        w_strb_q <= xPcieToDfx_AXI.wstrb;
      end
      if (commit) bresp_q <= wr_mapped ? OKAY : SLVERR;
      if (ar_hs) begin
        rdata_q <= rd_data_mux;
        rresp_q <= rd_mapped ? OKAY : SLVERR;
      end
      irq_q <= |mDoorbell;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign wr_en[c] = commit && wr_mapped && (wr_ch == 32'(c));

    dfx_ctrl_channel #(
      .CTRL_RST(CTRL_RST)
    ) u_ch (
      .clk     (AxiBusClock),
      .rst_n   (xAxiBusReset_n),
      .wr_en   (wr_en[c]),
      .wr_word (reg_word_e'(wr_addr[3:2])),
      .wr_data (wr_data),
      .wr_strb (wr_strb),
      .ack     (sDoorbellAck[c]),
      .status  (sMcuOutputControl[c*32 +: 32]),
      .rd_word (reg_word_e'(xPcieToDfx_AXI.araddr[3:2])),
      .ctrl    (sMcuInputControl[c*32 +: 32]),
      .pending (mDoorbell[c]),
      .rd_data (ch_rd_data[c])
    );
  end

  assign xPcieToDfx_AXI.awready = awready_q;
  assign xPcieToDfx_AXI.wready  = wready_q;
  assign xPcieToDfx_AXI.bvalid  = bvalid_q;
  assign xPcieToDfx_AXI.bresp   = bresp_q;
  assign xPcieToDfx_AXI.arready = arready_q;
  assign xPcieToDfx_AXI.rvalid  = rvalid_q;
  assign xPcieToDfx_AXI.rresp   = rresp_q;
  assign xPcieToDfx_AXI.rdata   = rdata_q;
  assign mDoorbellIrq           = irq_q;

endmodule

// File: tb/tb_dfx_axil_ctrl_regs.sv
// Self-checking bench for dfx_axil_ctrl_regs: directed AXI-Lite traffic against a register model.
module tb_dfx_axil_ctrl_regs;
  localparam int unsigned NUM_CH   = 2;
  localparam int unsigned ADDR_W   = 12;
  localparam logic [31:0] CTRL_RST = 32'h0000_00C3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NUM_CH*32-1:0] ctrl_out;
  logic [NUM_CH*32-1:0] status_in;
  logic [NUM_CH-1:0]    doorbell;
  logic [NUM_CH-1:0]    ack;
  logic                 irq;

  dfx_axil_ctrl_regs_if #(.ADDR_W(ADDR_W)) axi ();

  dfx_axil_ctrl_regs #(
    .NUM_CH  (NUM_CH),
    .ADDR_W  (ADDR_W),
    .CTRL_RST(CTRL_RST)
  ) dut (
    .AxiBusClock      (clk),
    .xAxiBusReset_n   (rst_n),
    .xPcieToDfx_AXI   (axi),
    .sMcuInputControl (ctrl_out),
    .sMcuOutputControl(status_in),
    .mDoorbell        (doorbell),
    .sDoorbellAck     (ack),
    .mDoorbellIrq     (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  logic cmp_en = 1'b0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endfunction

  // Register model: what the block's state must be, per channel.
  logic [31:0]       ctrl_m    [NUM_CH];
  logic [31:0]       scratch_m [NUM_CH];
  logic [31:0]       status_m  [NUM_CH];
  logic [NUM_CH-1:0] pending_m;
  logic              irq_m;
  // A write the bench has arranged to commit on the coming rising edge.
  logic              mw_fire = 1'b0;
  logic [ADDR_W-1:0] mw_addr = '0;
  logic [31:0]       mw_data = '0;
  logic [3:0]        mw_strb = '0;

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old & ~m) | (d & m);
  endfunction

  function automatic logic hit(int c, logic [1:0] w);
    return mw_fire && (mw_addr[1:0] == 2'b00) && (int'(mw_addr >> 4) == c) && (mw_addr[3:2] == w);
  endfunction

  function automatic logic [31:0] model_read(logic [ADDR_W-1:0] a);
    int c;
    c = int'(a >> 4);
    if (a[1:0] != 2'b00 || c >= int'(NUM_CH)) return 32'h0;
    case (a[3:2])
      2'd0:    return ctrl_m[c];
      2'd1:    return status_m[c];
      2'd2:    return {31'b0, pending_m[c]};
      default: return scratch_m[c];
    endcase
  endfunction

  function automatic logic [NUM_CH*32-1:0] ctrl_vec();
    logic [NUM_CH*32-1:0] v;
    for (int c = 0; c < int'(NUM_CH); c++) v[c*32 +: 32] = ctrl_m[c];
    return v;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < int'(NUM_CH); c++) begin
        ctrl_m[c]    <= CTRL_RST;
        scratch_m[c] <= '0;
        status_m[c]  <= '0;
      end
      pending_m <= '0;
      irq_m     <= 1'b0;
    end else begin
      irq_m <= |pending_m;
      for (int c = 0; c < int'(NUM_CH); c++) begin
        status_m[c] <= status_in[c*32 +: 32];
        if (hit(c, 2'd0)) ctrl_m[c] <= merge(ctrl_m[c], mw_data, mw_strb);
        if (hit(c, 2'd3)) scratch_m[c] <= merge(scratch_m[c], mw_data, mw_strb);
        if (hit(c, 2'd2) && mw_data[0] && mw_strb[0]) pending_m[c] <= 1'b1;
        else if (ack[c]) pending_m[c] <= 1'b0;
      end
    end
  end

  // Every cycle: MCU-side outputs must match the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("ctrl_out", 64'(ctrl_out), 64'(ctrl_vec()));
      chk("doorbell", 64'(doorbell), 64'(pending_m));
      chk("irq", 64'(irq), 64'(irq_m));
    end
  end

  // Starts and ends on a falling edge. W leads AW by w_lead cycles (0 = same cycle);
  // ack_c is driven for exactly the commit cycle.
  task automatic axi_write(input logic [ADDR_W-1:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int w_lead, input logic [1:0] exp_resp,
                           input logic [NUM_CH-1:0] ack_c);
    axi.wdata = data;
    axi.wstrb = strb;
    if (w_lead > 0) begin
      axi.wvalid = 1'b1;
      chk("wready_idle", 64'(axi.wready), 64'd1);
      @(negedge clk);
      axi.wvalid = 1'b0;
      chk("wready_held", 64'(axi.wready), 64'd0);
      chk("bvalid_early", 64'(axi.bvalid), 64'd0);
      repeat (w_lead - 1) @(negedge clk);
    end else begin
      axi.wvalid = 1'b1;
      chk("wready_idle", 64'(axi.wready), 64'd1);
    end
    axi.awaddr  = addr;
    axi.awvalid = 1'b1;
    chk("awready_idle", 64'(axi.awready), 64'd1);
    mw_addr = addr;
    mw_data = data;
    mw_strb = strb;
    mw_fire = 1'b1;
    ack     = ack_c;
    @(negedge clk);
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    mw_fire     = 1'b0;
    ack         = '0;
    chk("bvalid", 64'(axi.bvalid), 64'd1);
    chk("bresp", 64'(axi.bresp), 64'(exp_resp));
    chk("awready_busy", 64'(axi.awready), 64'd0);
    if (axi.bready) begin
      @(negedge clk);
      chk("bvalid_clear", 64'(axi.bvalid), 64'd0);
    end
  endtask

  task automatic axi_read(input logic [ADDR_W-1:0] addr, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp);
    axi.araddr  = addr;
    axi.arvalid = 1'b1;
    chk("arready_idle", 64'(axi.arready), 64'd1);
    @(negedge clk);
    axi.arvalid = 1'b0;
    chk("rvalid", 64'(axi.rvalid), 64'd1);
    chk("rdata", 64'(axi.rdata), 64'(exp_data));
    chk("rresp", 64'(axi.rresp), 64'(exp_resp));
    chk("arready_busy", 64'(axi.arready), 64'd0);
    @(negedge clk);
    chk("rvalid_clear", 64'(axi.rvalid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 1'b0;
    axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0; axi.bready = 1'b1;
    axi.araddr = '0; axi.arprot = '0; axi.arvalid = 1'b0; axi.rready = 1'b1;
    ack = '0;
    status_in = '0;

    // Reset values.
    @(posedge clk);
    cmp_en = 1'b1;
    @(negedge clk);
    chk("rst_awready", 64'(axi.awready), 64'd0);
    chk("rst_wready", 64'(axi.wready), 64'd0);
    chk("rst_arready", 64'(axi.arready), 64'd0);
    chk("rst_bvalid", 64'(axi.bvalid), 64'd0);
    chk("rst_rvalid", 64'(axi.rvalid), 64'd0);
    chk("rst_ctrl", 64'(ctrl_out), 64'h0000_00C3_0000_00C3);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_awready", 64'(axi.awready), 64'd1);
    chk("post_rst_wready", 64'(axi.wready), 64'd1);
    chk("post_rst_arready", 64'(axi.arready), 64'd1);

    // Full-word CTRL write on channel 1.
    axi_write(12'h010, 32'hA5A5_1234, 4'hF, 0, 2'b00, '0);
    chk("ctrl1_lit", 64'(ctrl_out[63:32]), 64'h0000_0000_A5A5_1234);
    chk("ctrl0_lit", 64'(ctrl_out[31:0]), 64'h0000_0000_0000_00C3);
    chk("model_pin_ctrl1", 64'(model_read(12'h010)), 64'h0000_0000_A5A5_1234);
    axi_read(12'h010, 32'hA5A5_1234, 2'b00);

    // Byte strobes on SCRATCH and CTRL.
    axi_write(12'h00C, 32'hFFFF_FFFF, 4'b0101, 0, 2'b00, '0);
    axi_read(12'h00C, 32'h00FF_00FF, 2'b00);
    axi_write(12'h000, 32'h1122_3344, 4'b1000, 0, 2'b00, '0);
    chk("model_pin_ctrl0", 64'(model_read(12'h000)), 64'h0000_0000_1100_00C3);
    axi_read(12'h000, 32'h1100_00C3, 2'b00);

    // Doorbell with W leading AW by 3 cycles.
    axi_write(12'h008, 32'h1, 4'hF, 3, 2'b00, '0);
    chk("db0_set", 64'(doorbell[0]), 64'd1);
    chk("irq_set", 64'(irq), 64'd1);
    axi_read(12'h008, 32'h1, 2'b00);
    ack = 2'b01;
    @(negedge clk);
    ack = '0;
    chk("db0_acked", 64'(doorbell[0]), 64'd0);
    @(negedge clk);
    chk("irq_clear", 64'(irq), 64'd0);

    // Doorbell writes of 0 and with byte 0 disabled do nothing.
    axi_write(12'h018, 32'h0, 4'hF, 0, 2'b00, '0);
    axi_write(12'h018, 32'h1, 4'b1110, 0, 2'b00, '0);
    chk("db1_noop", 64'(doorbell[1]), 64'd0);

    // Set and ack in the same cycle: set wins.
    axi_write(12'h018, 32'h1, 4'hF, 0, 2'b00, 2'b10);
    chk("db1_set_wins", 64'(doorbell[1]), 64'd1);
    axi_read(12'h018, model_read(12'h018), 2'b00);

    // Unmapped accesses.
    axi_read(12'h020, 32'h0, 2'b10);
    axi_write(12'h013, 32'hFFFF_FFFF, 4'hF, 0, 2'b10, '0);
    axi_read(12'h010, 32'hA5A5_1234, 2'b00);
    axi_read(12'h012, 32'h0, 2'b10);

    // STATUS sampling; writes to STATUS are ignored.
    status_in = {32'hCAFE_F00D, 32'h1234_5678};
    @(negedge clk);
    axi_read(12'h014, 32'hCAFE_F00D, 2'b00);
    axi_write(12'h004, 32'h0, 4'hF, 0, 2'b00, '0);
    axi_read(12'h004, 32'h1234_5678, 2'b00);
    status_in[31:0] = 32'h0BAD_0001;
    axi_read(12'h004, model_read(12'h004), 2'b00);
    axi_read(12'h004, 32'h0BAD_0001, 2'b00);

    // Back-pressure on B, then reset while the response is still pending.
    axi.bready = 1'b0;
    axi_write(12'h01C, 32'hDEAD_BEEF, 4'hF, 0, 2'b00, '0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_awready", 64'(axi.awready), 64'd0);
      chk("hold_wready", 64'(axi.wready), 64'd0);
      chk("hold_bvalid", 64'(axi.bvalid), 64'd1);
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_bvalid", 64'(axi.bvalid), 64'd0);
    chk("mid_rst_rvalid", 64'(axi.rvalid), 64'd0);
    chk("mid_rst_awready", 64'(axi.awready), 64'd0);
    chk("mid_rst_ctrl", 64'(ctrl_out), 64'h0000_00C3_0000_00C3);
    chk("mid_rst_db", 64'(doorbell), 64'd0);
    axi.bready = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rerst_awready", 64'(axi.awready), 64'd1);
    axi_read(12'h01C, 32'h0, 2'b00);
    axi_read(12'h010, 32'h0000_00C3, 2'b00);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
